// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute side signals of the branch resolve queue, bundled for port hookup.
// slave = queue side, master = driver of pushes and resolves.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          i_push;
    logic [31:0]   i_push_pc;
    logic          i_push_pred;
    logic [31:0]   i_push_target;
    logic          o_full;
    logic          o_empty;
    logic [CW-1:0] o_count;
    logic          i_resolve;
    logic          i_resolve_taken;
    logic [31:0]   i_resolve_target;
    logic          o_update_en;
    logic [31:0]   o_update_addr;
    logic          o_update_taken;
    logic          o_redirect;
    logic [31:0]   o_redirect_pc;
    logic          o_overflow;
    logic          o_underflow;

    modport slave (
        input  i_push, i_push_pc, i_push_pred, i_push_target,
        input  i_resolve, i_resolve_taken, i_resolve_target,
        output o_full, o_empty, o_count,
        output o_update_en, o_update_addr, o_update_taken,
        output o_redirect, o_redirect_pc, o_overflow, o_underflow
    );

    modport master (
        output i_push, i_push_pc, i_push_pred, i_push_target,
        output i_resolve, i_resolve_taken, i_resolve_target,
        input  o_full, o_empty, o_count,
        input  o_update_en, o_update_addr, o_update_taken,
        input  o_redirect, o_redirect_pc, o_overflow, o_underflow
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order branch prediction queue; training/redirect pulses registered, 1 cycle after resolve.
// Backpressure via o_full: pushes into a full queue are dropped and flagged in o_overflow.
module branch_resolve_queue #(
    parameter int DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    branch_resolve_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   pc_mem_d  [DEPTH];
    logic [31:0]   tgt_mem_q [DEPTH];
    logic [31:0]   tgt_mem_d [DEPTH];
    logic          pred_mem_q[DEPTH];
    logic          pred_mem_d[DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          update_en_q, update_en_d;
    logic [31:0]   update_addr_q, update_addr_d;
    logic          update_taken_q, update_taken_d;
    logic          redirect_q, redirect_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;

    logic [31:0]   head_pc;
    logic [31:0]   head_tgt;
    logic          head_pred;
    logic          do_res;
    logic          mispred;
    logic          pop_ok;
    logic          push_ok;

    always_comb begin
        head_pc   = pc_mem_q[rd_ptr_q];
        head_tgt  = tgt_mem_q[rd_ptr_q];
        head_pred = pred_mem_q[rd_ptr_q];

        do_res  = bus.i_resolve && (count_q != '0);
        mispred = do_res && ((head_pred != bus.i_resolve_taken) ||
                             (head_pred && bus.i_resolve_taken && (head_tgt != bus.i_resolve_target)));
        pop_ok  = do_res && !mispred;
        // A correct pop frees a slot in the same edge, so a full queue can still take a push.
        push_ok = bus.i_push && !mispred && ((count_q < CW'(DEPTH)) || pop_ok);

        pc_mem_d   = pc_mem_q;
        tgt_mem_d  = tgt_mem_q;
        pred_mem_d = pred_mem_q;
        if (push_ok) begin
            pc_mem_d[wr_ptr_q]   = bus.i_push_pc;
            tgt_mem_d[wr_ptr_q]  = bus.i_push_target;
            pred_mem_d[wr_ptr_q] = bus.i_push_pred;
        end

        if (mispred) begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_ok);
            rd_ptr_d = rd_ptr_q + AW'(pop_ok);
            count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        end

        // Wrong-path pushes during a flush are not an overflow.
        overflow_d  = overflow_q | (bus.i_push && !mispred && !push_ok);
        underflow_d = underflow_q | (bus.i_resolve && (count_q == '0));

        update_en_d    = do_res;
        update_addr_d  = do_res ? head_pc : update_addr_q;
        update_taken_d = do_res ? bus.i_resolve_taken : update_taken_q;
        redirect_d     = mispred;
        redirect_pc_d  = redirect_pc_q;
        if (mispred) begin
            redirect_pc_d = bus.i_resolve_taken ? bus.i_resolve_target : head_pc + 32'd4;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                tgt_mem_q[i]  <= '0;
                pred_mem_q[i] <= 1'b0;
            end
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            update_en_q    <= 1'b0;
            update_addr_q  <= '0;
            update_taken_q <= 1'b0;
            redirect_q     <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            pc_mem_q       <= pc_mem_d;
            tgt_mem_q      <= tgt_mem_d;
            pred_mem_q     <= pred_mem_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            update_en_q    <= update_en_d;
            update_addr_q  <= update_addr_d;
            update_taken_q <= update_taken_d;
            redirect_q     <= redirect_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    assign bus.o_count        = count_q;
    assign bus.o_full         = (count_q == CW'(DEPTH));
    assign bus.o_empty        = (count_q == '0);
    assign bus.o_overflow     = overflow_q;
    assign bus.o_underflow    = underflow_q;
    assign bus.o_update_en    = update_en_q;
    assign bus.o_update_addr  = update_addr_q;
    assign bus.o_update_taken = update_taken_q;
    assign bus.o_redirect     = redirect_q;
    assign bus.o_redirect_pc  = redirect_pc_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios with literal pins, then random traffic
// compared every cycle against a queue-based reference model.
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    branch_resolve_queue_if #(.DEPTH(DEPTH)) bus();

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    logic        m_upd_en, m_upd_taken, m_redir, m_ovf, m_unf;
    logic [31:0] m_upd_addr, m_redir_pc;
    bit          chk_on = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pop-then-push on a plain queue using pre-edge inputs.
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mq.delete();
            m_upd_en = 0; m_upd_taken = 0; m_redir = 0; m_ovf = 0; m_unf = 0;
            m_upd_addr = 0; m_redir_pc = 0;
        end else begin
            ent_t h;
            bit mis;
            mis = 0;
            m_upd_en = 0;
            m_redir = 0;
            if (bus.i_resolve) begin
                if (mq.size() == 0) begin
                    m_unf = 1;
                end else begin
                    h = mq.pop_front();
                    m_upd_en = 1;
                    m_upd_addr = h.pc;
                    m_upd_taken = bus.i_resolve_taken;
                    if (h.pred != bus.i_resolve_taken) mis = 1;
                    else if (h.pred && h.tgt != bus.i_resolve_target) mis = 1;
                    if (mis) begin
                        m_redir = 1;
                        m_redir_pc = bus.i_resolve_taken ? bus.i_resolve_target : h.pc + 32'd4;
                        mq.delete();
                    end
                end
            end
            if (bus.i_push && !mis) begin
                if (mq.size() < DEPTH)
                    mq.push_back('{pc: bus.i_push_pc, pred: bus.i_push_pred, tgt: bus.i_push_target});
                else
                    m_ovf = 1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (chk_on) begin
            chk("count",        32'(bus.o_count),  32'(mq.size()));
            chk("empty",        32'(bus.o_empty),  32'(mq.size() == 0));
            chk("full",         32'(bus.o_full),   32'(mq.size() == DEPTH));
            chk("update_en",    32'(bus.o_update_en),    32'(m_upd_en));
            chk("update_addr",  bus.o_update_addr,       m_upd_addr);
            chk("update_taken", 32'(bus.o_update_taken), 32'(m_upd_taken));
            chk("redirect",     32'(bus.o_redirect),     32'(m_redir));
            chk("redirect_pc",  bus.o_redirect_pc,       m_redir_pc);
            chk("overflow",     32'(bus.o_overflow),     32'(m_ovf));
            chk("underflow",    32'(bus.o_underflow),    32'(m_unf));
        end
    end

    // One clock: drive after a negedge, step through the posedge, return just past the next negedge.
    task automatic cyc(input logic psh, input logic [31:0] pc, input logic pred, input logic [31:0] tgt,
                       input logic res, input logic rtk, input logic [31:0] rtgt);
        bus.i_push = psh; bus.i_push_pc = pc; bus.i_push_pred = pred; bus.i_push_target = tgt;
        bus.i_resolve = res; bus.i_resolve_taken = rtk; bus.i_resolve_target = rtgt;
        @(posedge i_clk);
        @(negedge i_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
        cyc(1, pc, pred, tgt, 0, 0, 0);
    endtask

    task automatic resolve(input logic rtk, input logic [31:0] rtgt);
        cyc(0, 0, 0, 0, 1, rtk, rtgt);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_empty"},    32'(bus.o_empty), 1);
        chk({tag, "_full"},     32'(bus.o_full), 0);
        chk({tag, "_count"},    32'(bus.o_count), 0);
        chk({tag, "_upd_en"},   32'(bus.o_update_en), 0);
        chk({tag, "_redir"},    32'(bus.o_redirect), 0);
        chk({tag, "_upd_addr"}, bus.o_update_addr, 0);
        chk({tag, "_redir_pc"}, bus.o_redirect_pc, 0);
        chk({tag, "_ovf"},      32'(bus.o_overflow), 0);
        chk({tag, "_unf"},      32'(bus.o_underflow), 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_reset_vals("rst0");
        i_rst = 1'b0;
        chk_on = 1'b1;

        // 1: correct not-taken
        push(32'h100, 0, 0);
        resolve(0, 0);
        chk("t1_upd_en", 32'(bus.o_update_en), 1);
        chk("t1_addr", bus.o_update_addr, 32'h100);
        chk("t1_taken", 32'(bus.o_update_taken), 0);
        chk("t1_redir", 32'(bus.o_redirect), 0);
        chk("t1_empty", 32'(bus.o_empty), 1);

        // 2: direction mispredict, taken
        push(32'h200, 0, 0);
        resolve(1, 32'h80);
        chk("t2_taken", 32'(bus.o_update_taken), 1);
        chk("t2_redir", 32'(bus.o_redirect), 1);
        chk("t2_redir_pc", bus.o_redirect_pc, 32'h80);

        // 3: target mispredict, then predicted-taken but not taken
        push(32'h300, 1, 32'h400);
        resolve(1, 32'h500);
        chk("t3a_redir", 32'(bus.o_redirect), 1);
        chk("t3a_redir_pc", bus.o_redirect_pc, 32'h500);
        push(32'h300, 1, 32'h400);
        resolve(0, 32'h0);
        chk("t3b_redir_pc", bus.o_redirect_pc, 32'h304);

        // 4: fill, overflow, push with correct pop, drain in order
        push(32'h10, 0, 0); push(32'h20, 0, 0); push(32'h30, 0, 0); push(32'h40, 0, 0);
        chk("t4_full", 32'(bus.o_full), 1);
        push(32'h50, 0, 0);
        chk("t4_ovf", 32'(bus.o_overflow), 1);
        chk("t4_full2", 32'(bus.o_full), 1);
        cyc(1, 32'h60, 0, 0, 1, 0, 0);
        chk("t4_count", 32'(bus.o_count), 4);
        chk("t4_pop0", bus.o_update_addr, 32'h10);
        resolve(0, 0); chk("t4_pop1", bus.o_update_addr, 32'h20);
        resolve(0, 0); chk("t4_pop2", bus.o_update_addr, 32'h30);
        resolve(0, 0); chk("t4_pop3", bus.o_update_addr, 32'h40);
        resolve(0, 0); chk("t4_pop4", bus.o_update_addr, 32'h60);
        chk("t4_empty", 32'(bus.o_empty), 1);

        // 5: mispredict flush drops a same-cycle push
        push(32'hA00, 0, 0); push(32'hA10, 0, 0); push(32'hA20, 0, 0);
        cyc(1, 32'h900, 0, 0, 1, 1, 32'h1234);
        chk("t5_redir", 32'(bus.o_redirect), 1);
        chk("t5_count", 32'(bus.o_count), 0);
        resolve(0, 0);
        chk("t5_redir_once", 32'(bus.o_redirect), 0);
        chk("t5_no_900", bus.o_update_addr, 32'hA00);

        // 6: resolve on empty, then async reset with entries queued
        chk("t6_unf_pre", 32'(bus.o_underflow), 1);
        chk("t6_upd_en", 32'(bus.o_update_en), 0);
        push(32'hB00, 0, 0);
        cyc(1, 32'hB10, 0, 0, 1, 0, 0);
        #2 i_rst = 1'b1;
        #1 check_reset_vals("t6_rst");
        cyc(0, 0, 0, 0, 0, 0, 0);
        i_rst = 1'b0;
        resolve(0, 0);
        chk("t6_no_upd", 32'(bus.o_update_en), 0);
        chk("t6_unf", 32'(bus.o_underflow), 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic        psh, pred, res, rtk;
            logic [31:0] pc, tgt, rtgt;
            if ($urandom_range(0, 299) == 0) begin
                i_rst = 1'b1;
                cyc(0, 0, 0, 0, 0, 0, 0);
                i_rst = 1'b0;
            end else begin
                psh  = ($urandom_range(0, 9) < 6);
                pc   = {$urandom} & 32'hFFFF_FFFC;
                pred = $urandom_range(0, 1) != 0;
                tgt  = 32'($urandom_range(0, 3)) << 4;
                res  = ($urandom_range(0, 9) < 5);
                rtk  = $urandom_range(0, 1) != 0;
                rtgt = 32'($urandom_range(0, 3)) << 4;
                if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
                    rtk  = mq[0].pred;
                    rtgt = mq[0].tgt;
                end
                cyc(psh, pc, pred, tgt, res, rtk, rtgt);
            end
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
